// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-step restoring divider/remainder unit with flush
// Signed operands are reduced to magnitudes at accept and sign-corrected on the way into DONE.
`timescale 1ns/1ps
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_en,
    input  logic             div_operation,
    input  logic             div_unsigned,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [4:0]       LAST_STEP = 5'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             op_div_q, op_div_d;

    logic             sign_a, sign_b, div_zero, overflow;
    logic [WIDTH-1:0] mag_a, mag_b, quo_fin, rem_fin;
    logic [WIDTH:0]   rem_shift, diff;

    always_comb begin
        sign_a    = ~div_unsigned & operand_a[WIDTH-1];
        sign_b    = ~div_unsigned & operand_b[WIDTH-1];
        mag_a     = sign_a ? -operand_a : operand_a;
        mag_b     = sign_b ? -operand_b : operand_b;
        div_zero  = (operand_b == '0);
        overflow  = ~div_unsigned && (operand_a == MIN_NEG) && (operand_b == '1);

        // Partial remainder stays below the divisor, so the sign of the 33-bit difference decides the step.
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, dvs_q};
        quo_fin   = neg_quo_q ? -quo_q : quo_q;
        rem_fin   = neg_rem_q ? -rem_q : rem_q;

        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        result_d  = result_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        op_div_d  = op_div_q;

        case (state_q)
            IDLE: begin
                if (div_en) begin
                    op_div_d = div_operation;
                    if (div_zero) begin
                        result_d = div_operation ? '1 : operand_a;
                        state_d  = DONE;
                    end else if (overflow) begin
                        result_d = div_operation ? MIN_NEG : '0;
                        state_d  = DONE;
                    end else begin
                        rem_d     = '0;
                        quo_d     = mag_a;
                        dvs_d     = mag_b;
                        neg_quo_d = sign_a ^ sign_b;
                        neg_rem_d = sign_a;
                        cnt_d     = '0;
                        last_d    = 1'b0;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                if (!last_q) begin
                    rem_d  = diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
                    quo_d  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
                    cnt_d  = cnt_q + 5'd1;
                    last_d = (cnt_q == LAST_STEP);
                end else begin
                    result_d = op_div_q ? quo_fin : rem_fin;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // An abort wins over both a new accept and a completing operation.
        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            op_div_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            result_q  <= result_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            op_div_q  <= op_div_d;
        end
    end

    assign result = result_q;
    assign valid  = (state_q == DONE);
    assign busy   = (state_q != IDLE);
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit: directed corner cases, aborts and random operations
`timescale 1ns/1ps
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst_n, div_en, div_operation, div_unsigned, flush;
    logic [31:0] operand_a, operand_b, result;
    logic        valid, busy;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          due;
        int          bcnt;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          busy_cnt = 0;
    logic [31:0] model_last = '0;
    bit          mon_en = 1'b0;

    div_unit #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .div_en        (div_en),
        .div_operation (div_operation),
        .div_unsigned  (div_unsigned),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .flush         (flush),
        .result        (result),
        .valid         (valid),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RISC-V division semantics from plain 64-bit arithmetic; -2^31 / -1 wraps naturally.
    function automatic logic [31:0] ref_model(input bit op, input bit uns,
                                              input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return op ? 32'hFFFF_FFFF : a;
        if (uns) return op ? a / b : a % b;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return op ? q[31:0] : r[31:0];
    endfunction

    function automatic bit is_special(input bit uns, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!uns && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Monitor: pops the scoreboard on every valid pulse, otherwise checks that result holds.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (valid) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_valid", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("result", result, e.res);
                    chk("valid_cycle", cyc, e.due);
                    chk("busy_cycles", busy_cnt, e.bcnt);
                    model_last = e.res;
                end
                busy_cnt = 0;
            end else begin
                if (sb_q.size() > 0 && cyc >= sb_q[0].acc && busy) busy_cnt++;
                chk("result_hold", result, model_last);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy !== 1'b0) chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic issue(input bit op, input bit uns, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        bit   sp;
        wait_idle();
        sp            = is_special(uns, a, b);
        div_en        = 1'b1;
        div_operation = op;
        div_unsigned  = uns;
        operand_a     = a;
        operand_b     = b;
        e.res  = ref_model(op, uns, a, b);
        e.acc  = cyc + 1;
        e.due  = e.acc + (sp ? 0 : 33);
        e.bcnt = sp ? 0 : 33;
        sb_q.push_back(e);
        @(posedge clk); #1;
        div_en        = 1'b0;
        operand_a     = $urandom;
        operand_b     = $urandom;
        div_operation = 1'($urandom_range(1));
        div_unsigned  = 1'($urandom_range(1));
    endtask

    task automatic drop_inflight(input bit was_reset);
        exp_t e;
        if (sb_q.size() > 0) e = sb_q.pop_back();
        busy_cnt = 0;
        if (was_reset) model_last = '0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, valid}, 32'd0);
        chk("abort_result", result, model_last);
    endtask

    initial begin
        rst_n = 1'b0; div_en = 1'b0; div_operation = 1'b0; div_unsigned = 1'b0;
        flush = 1'b0; operand_a = '0; operand_b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_result", result, 32'd0);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        mon_en = 1'b1;

        issue(1'b1, 1'b0, 32'd100, 32'd7);
        issue(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2);
        issue(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
        issue(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1);
        issue(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h10);
        issue(1'b1, 1'b0, 32'd1234, 32'd0);
        issue(1'b0, 1'b0, 32'd1234, 32'd0);
        issue(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(1'b0, 1'b0, 32'd100, 32'hFFFF_FFF9);

        // Flush ten cycles into CALC, then a normal accept.
        issue(1'b1, 1'b0, 32'd1000, 32'd3);
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        drop_inflight(1'b0);
        issue(1'b1, 1'b0, 32'd77, 32'd5);

        // Flush landing on the completion edge must still suppress valid.
        issue(1'b0, 1'b1, 32'd999, 32'd10);
        repeat (32) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        drop_inflight(1'b0);

        // Flush beats div_en in IDLE.
        wait_idle();
        flush = 1'b1; div_en = 1'b1; operand_a = 32'd50; operand_b = 32'd5;
        @(posedge clk); #1;
        flush = 1'b0; div_en = 1'b0;
        chk("flush_vs_en_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of CALC.
        issue(1'b1, 1'b0, 32'd123456, 32'd789);
        repeat (15) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drop_inflight(1'b1);
        issue(1'b1, 1'b0, 32'hFFFF_FF9C, 32'd7);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            bit          op, uns;
            int          sel;
            a   = $urandom;
            b   = $urandom;
            op  = 1'($urandom_range(1));
            uns = 1'($urandom_range(1));
            sel = $urandom_range(9);
            case (sel)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(16, 1);
                3: a = $urandom_range(100);
                default: ;
            endcase
            issue(op, uns, a, b);
            if (!is_special(uns, a, b)) begin
                // div_en while busy must be ignored.
                repeat (3) begin @(posedge clk); #1; end
                for (int k = 0; k < 3; k++) begin
                    div_en    = 1'b1;
                    operand_a = $urandom;
                    operand_b = $urandom;
                    @(posedge clk); #1;
                end
                div_en = 1'b0;
            end
        end

        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
